// File: rtl/imem_load_sequencer.sv
// Instruction-memory port owner: holds the CPU, optionally clears memory to NOPs, loads a program
// from a valid/ready word stream, then releases the CPU and forwards fetch addresses. Option macro: IMEM_CLEAR_EN.
module imem_load_sequencer #(
    parameter int          DEPTH    = 101,
    parameter int          AW       = 7,
    parameter logic [31:0] NOP_WORD = 32'hE000_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          load_valid,
    input  logic [31:0]   load_data,
    input  logic          load_last,
    output logic          load_ready,
    input  logic [31:0]   fetch_addr,
    output logic          fetch_oob,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_hold,
    output logic          done,
    output logic [AW:0]   word_count,
    output logic          overflow
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        LOAD   = 3'd2,
        FINISH = 3'd3,
        RUN    = 3'd4
    } state_e;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

`ifdef IMEM_CLEAR_EN
    localparam logic [AW:0] LAST_C  = (AW+1)'(DEPTH - 1);
    localparam state_e      START_ST = CLEAR;
`else
    localparam state_e      START_ST = LOAD;
`endif

    state_e        state_q, state_d;
    // Pointer is one bit wider than the address so it can sit at DEPTH once memory is full.
    logic [AW:0]   ptr_q, ptr_d;
    logic [AW:0]   wc_q, wc_d;
    logic          ovf_q, ovf_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          in_run;
    logic          hs;

    assign in_run = (state_q == RUN);
    assign hs     = load_valid && load_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wc_d    = wc_q;
        ovf_d   = ovf_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE, RUN: begin
                if (start) begin
                    state_d = START_ST;
                    ptr_d   = '0;
                    wc_d    = '0;
                    ovf_d   = 1'b0;
                end
            end
`ifdef IMEM_CLEAR_EN
            CLEAR: begin
                we_d    = 1'b1;
                waddr_d = ptr_q[AW-1:0];
                wdata_d = NOP_WORD;
                if (ptr_q == LAST_C) begin
                    ptr_d   = '0;
                    state_d = LOAD;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
`endif
            LOAD: begin
                if (hs) begin
                    // Words beyond DEPTH are still accepted so the source can drain, but never written.
                    if (ptr_q < DEPTH_C) begin
                        we_d    = 1'b1;
                        waddr_d = ptr_q[AW-1:0];
                        wdata_d = load_data;
                        ptr_d   = ptr_q + 1'b1;
                        wc_d    = wc_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (load_last) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                state_d = RUN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            wc_q    <= '0;
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wc_q    <= wc_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign load_ready = (state_q == LOAD);
    assign cpu_hold   = !in_run;
    assign done       = in_run;
    assign word_count = wc_q;
    assign overflow   = ovf_q;
    assign mem_we     = we_q && !in_run;
    assign mem_wdata  = wdata_q;
    assign mem_addr   = in_run ? fetch_addr[AW+1:2] : waddr_q;
    assign fetch_oob  = in_run && ({2'b00, fetch_addr[31:2]} >= 32'(DEPTH));

    // Byte-offset bits never address memory; NOP_WORD is only consumed when the clear phase is built.
    logic unused_ok;
    assign unused_ok = ^{fetch_addr[1:0], NOP_WORD};

endmodule

// File: doc/imem_load_sequencer.md
Name: imem_load_sequencer

Overview:
Owns the single port of the instruction memory. After reset it holds the CPU and optionally clears the memory to NOPs. It then loads a program from an external word stream over a valid/ready handshake into word addresses 0 upward. Once loading finishes it releases the CPU and passes fetch addresses through to memory.

Parameters:
DEPTH, 101, number of 32-bit instruction words in memory
AW, 7, memory word-address width (2^AW >= DEPTH)
NOP_WORD, 32'hE000_0000, fill pattern used by the clear phase (AL-condition AND R0,R0,R0)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, synchronous, active-low (0 = reset)
start  input  1  one-cycle pulse; begins a (re)load
load_valid  input  1  load stream word valid
load_data  input  32  load stream instruction word
load_last  input  1  marks the final word of the program; qualified by load_valid
load_ready  output  1  sequencer accepts a word this cycle
fetch_addr  input  32  PC byte address from the fetch stage
fetch_oob  output  1  fetch word index >= DEPTH (RUN only)
mem_we  output  1  instruction memory write enable
mem_addr  output  AW  instruction memory word address
mem_wdata  output  32  instruction memory write data
cpu_hold  output  1  freeze PC and pipeline
done  output  1  program loaded, CPU running
word_count  output  AW+1  words written by the last load, saturating at DEPTH
overflow  output  1  sticky; load stream exceeded DEPTH words

Behaviour:
- States: IDLE, CLEAR, LOAD, FINISH, RUN. All flops update on the rising edge of clk.
- Reset (rst=0 at an edge):
  - state=IDLE, word_count=0, overflow=0.
  - Internal write pointer=0; registered mem_we=0, mem_addr=0, mem_wdata=0.
  - Applies from any state, including mid-CLEAR or mid-LOAD; a partial load is abandoned.
- Output decode by state:
  - cpu_hold=1 in every state except RUN.
  - done=1 only in RUN.
  - load_ready=1 only in LOAD.
- IDLE:
  - mem_we=0.
  - start: go to CLEAR (feature on) or LOAD (feature off); write pointer=0, word_count=0, overflow=0.
- CLEAR:
  - Each cycle, registered write of NOP_WORD to the pointer address; pointer increments.
  - After the write to address DEPTH-1, pointer=0 and state goes to LOAD.
  - Takes exactly DEPTH cycles.
  - load_ready=0, so no stream words are lost.
- LOAD:
  - Handshake occurs when load_valid && load_ready.
  - On a handshake with pointer < DEPTH: next cycle mem_we=1, mem_addr=pointer, mem_wdata=load_data. Pointer and word_count increment. Write latency is one cycle.
  - On a handshake with pointer == DEPTH: word dropped, mem_we=0, overflow set. load_ready stays 1 so the source drains; word_count holds at DEPTH.
  - A handshake with load_last=1 goes to FINISH.
  - Without a handshake, mem_we=0 next cycle.
  - A load_last=1 handshake on the first word is legal (one-word program).
- FINISH:
  - The registered write of the last word completes; cpu_hold still 1.
  - Next cycle: RUN.
- RUN:
  - mem_we=0.
  - mem_addr=fetch_addr[AW+1:2], combinational.
  - fetch_oob=1 when fetch_addr[31:2] >= DEPTH; fetch_oob=0 in all other states.
  - start: reload via CLEAR/LOAD exactly as from IDLE; cpu_hold asserts the next cycle.
- start is ignored in CLEAR, LOAD and FINISH.
- mem_addr in IDLE/CLEAR/LOAD/FINISH is the registered write address.

Optional Feature:
IMEM_CLEAR_EN
- Defined: CLEAR state exists; unloaded words read as NOP_WORD.
- Undefined: CLEAR is omitted; start goes directly to LOAD; unloaded words keep their prior contents.
- All other timing is identical.

Test Plan:
- Reset, no feature: rst=0 for 2 cycles, then start and stream 6 words with last on word 6 -> writes at addresses 0..5 one cycle after each handshake; FINISH for 1 cycle; then cpu_hold=0, done=1, word_count=6.
- Backpressure gaps: load_valid toggled 1,0,1,0 -> mem_we pulses only after valid cycles; addresses contiguous 0,1.
- Overflow: stream 103 words with last on word 103 -> 101 writes, overflow=1, word_count=101, load_ready=1 throughout, RUN reached.
- RUN fetch: fetch_addr=0x0000_0010 -> mem_addr=4, mem_we=0; fetch_addr=0x0000_0194 -> fetch_oob=1.
- Reset mid-LOAD after 3 words -> IDLE, word_count=0, cpu_hold=1, load_ready=0 next cycle.
- IMEM_CLEAR_EN: start -> 101 writes of 0xE000_0000 at addresses 0..100, load_ready=0 during them, then LOAD. start asserted during RUN -> cpu_hold=1 next cycle and clear restarts at address 0.
